fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the write port of the async FIFO between NREQ requesters, all in the write clock domain.
- Grants one requester at a time for a burst, which ends on req_last or after MAX_BURST beats.
- Muxes the owner's data onto wdata/winc and applies wfull backpressure to the owner only.
- Sits directly in front of the FIFO write side (winc, wdata, wfull).

---
 rtl/fifo_wr_arbiter.sv | 157 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for the shared write port of an async FIFO. It grants bursts, muxes the owner onto winc/wdata and applies wfull backpressure to the owner only.
// Optional: define FIFO_WR_ARB_STALL_CNT_EN to add a saturating stall_cnt output.
module fifo_wr_arbiter #(
    parameter int DATASIZE  = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                     wclk,
    input  logic                     wrst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATASIZE-1:0] req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          grant,
    output logic                     busy,
    output logic                     winc,
    output logic [DATASIZE-1:0]      wdata,
    input  logic                     wfull
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [OW:0]   NREQ_W   = (OW + 1)'(NREQ);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

    // Handshake: a beat moves when req_valid[owner] & req_ready[owner]; that is exactly winc.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   last_owner_q, last_owner_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

    logic                own_valid;
    logic                own_last;
    logic [DATASIZE-1:0] own_data;
    logic                accept;
    logic                burst_end;
    logic                sel_found;
    logic [OW-1:0]       sel_idx;
    logic [OW:0]         cand;

    // Search upward from last_owner+1, wrapping at NREQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = last_owner_q;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, last_owner_q} + (OW + 1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!sel_found && req_valid[cand[OW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[OW-1:0];
            end
        end
    end

    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == OW'(i)) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_data  = req_data[i*DATASIZE +: DATASIZE];
            end
        end
    end

    assign accept    = (state_q == BUSY) & own_valid & ~wfull;
    assign burst_end = accept & (own_last | (beat_cnt_q == LAST_CNT));

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= OW'(NREQ - 1);
            grant_q      <= '0;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            grant_q      <= grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        grant_d      = grant_q;
        beat_cnt_d   = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d          = BUSY;
                    owner_d          = sel_idx;
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                end
            end
            BUSY: begin
                if (burst_end) begin
                    state_d      = IDLE;
                    grant_d      = '0;
                    last_owner_d = owner_q;
                    beat_cnt_d   = '0;
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == BUSY);
        req_ready = '0;
        winc      = 1'b0;
        wdata     = '0;
        if (state_q == BUSY) begin
            req_ready[owner_q] = ~wfull;
            winc               = accept;
            wdata              = own_data;
        end
    end

    assign grant = grant_q;

`ifdef FIFO_WR_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            stall_cnt_q <= '0;
        end else if ((state_q == BUSY) && own_valid && wfull && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_fifo_wr_arbiter;

    localparam int DATASIZE  = 8;
    localparam int NREQ      = 4;
    localparam int MAX_BURST = 8;

    logic                     wclk = 1'b0;
    logic                     wrst_n;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ*DATASIZE-1:0] req_data;
    logic [NREQ-1:0]          req_last;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ-1:0]          grant;
    logic                     busy;
    logic                     winc;
    logic [DATASIZE-1:0]      wdata;
    logic                     wfull;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    logic [15:0]              stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [DATASIZE-1:0] exp_q[$];

    fifo_wr_arbiter #(
        .DATASIZE (DATASIZE),
        .NREQ     (NREQ),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_last (req_last),
        .req_ready(req_ready),
        .grant    (grant),
        .busy     (busy),
        .winc     (winc),
        .wdata    (wdata),
        .wfull    (wfull)
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    // Clock / reset
    always #5 wclk = ~wclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic next_cycle();
        @(posedge wclk);
        #1;
    endtask

    task automatic set_data(input int idx, input logic [DATASIZE-1:0] v);
        req_data[idx*DATASIZE +: DATASIZE] = v;
    endtask

    task automatic do_reset();
        wrst_n    = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        wfull     = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        wrst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        wrst_n    = 1'b0;
        req_valid = '1;
        req_last  = '0;
        req_data  = '1;
        wfull     = 1'b0;
        repeat (2) @(negedge wclk);
        n_cmp++;
        if (grant !== '0 || busy !== 1'b0 || winc !== 1'b0 || req_ready !== '0 || wdata !== '0) begin
            n_err++;
            $display("FAIL reset_state: grant=%b busy=%b winc=%b ready=%b wdata=%h expected all zero",
                     grant, busy, winc, req_ready, wdata);
        end
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        n_cmp++;
        if (stall_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
        end
`endif
    endtask

    task automatic test_single_burst();
        logic [DATASIZE-1:0] w;
        do_reset();
        req_valid = 4'b0001;
        set_data(0, 8'hA1);
        exp_q = {8'hA1, 8'hA2, 8'hA3};
        @(negedge wclk);
        n_cmp++;
        if (grant !== 4'b0000 || winc !== 1'b0) begin
            n_err++;
            $display("FAIL single_arb_latency: grant=%b winc=%b expected grant=0000 winc=0", grant, winc);
        end
        next_cycle();
        for (int b = 0; b < 3; b++) begin
            set_data(0, 8'hA1 + 8'(b));
            req_last = (b == 2) ? 4'b0001 : 4'b0000;
            @(negedge wclk);
            n_cmp++;
            if (grant !== 4'b0001 || winc !== 1'b1 || req_ready !== 4'b0001) begin
                n_err++;
                $display("FAIL single_beat%0d: grant=%b winc=%b ready=%b expected 0001/1/0001",
                         b, grant, winc, req_ready);
            end
            if (winc === 1'b1 && exp_q.size() > 0) begin
                w = exp_q.pop_front();
                n_cmp++;
                if (wdata !== w) begin
                    n_err++;
                    $display("FAIL single_wdata%0d: got %h expected %h", b, wdata, w);
                end
            end
            next_cycle();
        end
        req_valid = '0;
        req_last  = '0;
        @(negedge wclk);
        n_cmp++;
        if (grant !== 4'b0000 || busy !== 1'b0 || winc !== 1'b0) begin
            n_err++;
            $display("FAIL single_end: grant=%b busy=%b winc=%b expected 0000/0/0", grant, busy, winc);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0]     eg;
        logic [DATASIZE-1:0] d [NREQ];
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            d[i] = 8'($urandom_range(0, 255));
            set_data(i, d[i]);
        end
        req_valid = '1;
        req_last  = '1;
        for (int n = 0; n < 5; n++) begin
            eg = NREQ'(1) << (n % NREQ);
            @(negedge wclk);
            n_cmp++;
            if (grant !== '0 || winc !== 1'b0) begin
                n_err++;
                $display("FAIL rr_bubble%0d: grant=%b winc=%b expected 0000/0", n, grant, winc);
            end
            next_cycle();
            @(negedge wclk);
            n_cmp++;
            if (grant !== eg || winc !== 1'b1 || wdata !== d[n % NREQ]) begin
                n_err++;
                $display("FAIL rr_grant%0d: grant=%b winc=%b wdata=%h expected %b/1/%h",
                         n, grant, winc, wdata, eg, d[n % NREQ]);
            end
            next_cycle();
        end
        req_valid = '0;
        req_last  = '0;
        next_cycle();
    endtask

    task automatic test_max_burst();
        int n_winc;
        do_reset();
        req_valid = 4'b0100;
        next_cycle();
        n_winc = 0;
        for (int b = 0; b < MAX_BURST; b++) begin
            set_data(2, 8'($urandom_range(0, 255)));
            @(negedge wclk);
            if (winc === 1'b1) n_winc++;
            n_cmp++;
            if (grant !== 4'b0100 || wdata !== req_data[2*DATASIZE +: DATASIZE]) begin
                n_err++;
                $display("FAIL maxb_beat%0d: grant=%b wdata=%h expected 0100/%h",
                         b, grant, wdata, req_data[2*DATASIZE +: DATASIZE]);
            end
            next_cycle();
        end
        n_cmp++;
        if (n_winc != MAX_BURST) begin
            n_err++;
            $display("FAIL maxb_count: got %0d winc pulses expected %0d", n_winc, MAX_BURST);
        end
        @(negedge wclk);
        n_cmp++;
        if (grant !== 4'b0000 || winc !== 1'b0) begin
            n_err++;
            $display("FAIL maxb_bubble: grant=%b winc=%b expected 0000/0", grant, winc);
        end
        next_cycle();
        @(negedge wclk);
        n_cmp++;
        if (grant !== 4'b0100 || winc !== 1'b1) begin
            n_err++;
            $display("FAIL maxb_regrant: grant=%b winc=%b expected 0100/1", grant, winc);
        end
        next_cycle();
        req_valid = '0;
    endtask

    task automatic test_stall();
        int beat;
        logic [DATASIZE-1:0] w;
        do_reset();
        req_valid = 4'b0010;
        for (int b = 0; b < MAX_BURST; b++) exp_q.push_back(8'h50 + 8'(b));
        next_cycle();
        beat = 0;
        for (int c = 0; c < MAX_BURST + 5; c++) begin
            wfull = (c >= 2 && c < 7);
            set_data(1, 8'h50 + 8'(beat));
            @(negedge wclk);
            n_cmp++;
            if (wfull) begin
                if (winc !== 1'b0 || req_ready !== '0 || grant !== 4'b0010) begin
                    n_err++;
                    $display("FAIL stall_hold%0d: winc=%b ready=%b grant=%b expected 0/0000/0010",
                             c, winc, req_ready, grant);
                end
            end else begin
                w = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                if (winc !== 1'b1 || wdata !== w || grant !== 4'b0010) begin
                    n_err++;
                    $display("FAIL stall_beat%0d: winc=%b wdata=%h grant=%b expected 1/%h/0010",
                             c, winc, wdata, grant, w);
                end
            end
            if (winc === 1'b1) beat++;
            next_cycle();
        end
        wfull = 1'b0;
        @(negedge wclk);
        n_cmp++;
        if (beat != MAX_BURST || grant !== 4'b0000) begin
            n_err++;
            $display("FAIL stall_end: beats=%0d grant=%b expected %0d/0000", beat, grant, MAX_BURST);
        end
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        n_cmp++;
        if (stall_cnt !== 16'd5) begin
            n_err++;
            $display("FAIL stall_cnt: got %0d expected 5", stall_cnt);
        end
`endif
        req_valid = '0;
        next_cycle();
    endtask

    task automatic test_owner_drop();
        do_reset();
        set_data(0, 8'h11);
        set_data(3, 8'h33);
        req_valid = 4'b1001;
        next_cycle();
        @(negedge wclk);
        n_cmp++;
        if (grant !== 4'b0001 || winc !== 1'b1 || wdata !== 8'h11) begin
            n_err++;
            $display("FAIL drop_first: grant=%b winc=%b wdata=%h expected 0001/1/11", grant, winc, wdata);
        end
        next_cycle();
        req_valid = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            @(negedge wclk);
            n_cmp++;
            if (grant !== 4'b0001 || winc !== 1'b0 || req_ready !== 4'b0001) begin
                n_err++;
                $display("FAIL drop_hold%0d: grant=%b winc=%b ready=%b expected 0001/0/0001",
                         c, grant, winc, req_ready);
            end
            next_cycle();
        end
        req_valid = 4'b1001;
        req_last  = 4'b0001;
        @(negedge wclk);
        n_cmp++;
        if (grant !== 4'b0001 || winc !== 1'b1) begin
            n_err++;
            $display("FAIL drop_last: grant=%b winc=%b expected 0001/1", grant, winc);
        end
        next_cycle();
        req_last = '0;
        @(negedge wclk);
        n_cmp++;
        if (grant !== 4'b0000) begin
            n_err++;
            $display("FAIL drop_bubble: grant=%b expected 0000", grant);
        end
        next_cycle();
        @(negedge wclk);
        n_cmp++;
        if (grant !== 4'b1000 || wdata !== 8'h33) begin
            n_err++;
            $display("FAIL drop_next: grant=%b wdata=%h expected 1000/33", grant, wdata);
        end
        req_valid = '0;
        next_cycle();
    endtask

    task automatic test_async_reset();
        do_reset();
        req_valid = 4'b0100;
        next_cycle();
        next_cycle();
        req_valid = 4'b0101;
        #2;
        wrst_n = 1'b0;
        #1;
        n_cmp++;
        if (grant !== '0 || busy !== 1'b0 || winc !== 1'b0 || req_ready !== '0) begin
            n_err++;
            $display("FAIL async_reset: grant=%b busy=%b winc=%b ready=%b expected zeros",
                     grant, busy, winc, req_ready);
        end
        @(negedge wclk);
        wrst_n = 1'b1;
        next_cycle();
        @(negedge wclk);
        n_cmp++;
        if (grant !== 4'b0001) begin
            n_err++;
            $display("FAIL async_rewin: grant=%b expected 0001", grant);
        end
        req_valid = '0;
        next_cycle();
    endtask

    // Scoreboard: transaction-level model of arbitration and bursts.
    task automatic test_random();
        int m_busy, m_owner, m_cnt, m_last, m_stall;
        logic [NREQ-1:0]     e_grant, e_ready;
        logic                e_winc;
        logic [DATASIZE-1:0] e_wdata;
        do_reset();
        m_busy  = 0;
        m_owner = 0;
        m_cnt   = 0;
        m_last  = NREQ - 1;
        m_stall = 0;
        for (int c = 0; c < 1500; c++) begin
            req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                req_last[i] = ($urandom_range(0, 3) == 0);
                set_data(i, 8'($urandom_range(0, 255)));
            end
            wfull = ($urandom_range(0, 3) == 0);
            @(negedge wclk);
            e_grant = (m_busy != 0) ? (NREQ'(1) << m_owner) : '0;
            e_ready = (m_busy != 0 && !wfull) ? e_grant : '0;
            e_winc  = (m_busy != 0) && req_valid[m_owner] && !wfull;
            e_wdata = (m_busy != 0) ? req_data[m_owner*DATASIZE +: DATASIZE] : '0;
            if (e_winc) exp_q.push_back(e_wdata);
            n_cmp++;
            if (grant !== e_grant || busy !== (m_busy != 0)) begin
                n_err++;
                $display("FAIL rand_grant c%0d: grant=%b busy=%b expected %b/%0d", c, grant, busy, e_grant, m_busy);
            end
            n_cmp++;
            if (winc !== e_winc || req_ready !== e_ready || wdata !== e_wdata) begin
                n_err++;
                $display("FAIL rand_port c%0d: winc=%b ready=%b wdata=%h expected %b/%b/%h",
                         c, winc, req_ready, wdata, e_winc, e_ready, e_wdata);
            end
            if (winc === 1'b1 && exp_q.size() > 0) begin
                n_cmp++;
                if (wdata !== exp_q.pop_front()) begin
                    n_err++;
                    $display("FAIL rand_sb c%0d: wdata=%h out of order", c, wdata);
                end
            end
            if (m_busy != 0 && req_valid[m_owner] && wfull && m_stall < 65535) m_stall++;
            if (m_busy == 0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (m_busy == 0 && req_valid[(m_last + k) % NREQ]) begin
                        m_owner = (m_last + k) % NREQ;
                        m_busy  = 1;
                    end
                end
            end else if (e_winc) begin
                m_cnt++;
                if (req_last[m_owner] || m_cnt == MAX_BURST) begin
                    m_busy = 0;
                    m_last = m_owner;
                    m_cnt  = 0;
                end
            end
            next_cycle();
        end
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        n_cmp++;
        if (stall_cnt !== 16'(m_stall)) begin
            n_err++;
            $display("FAIL rand_stall_cnt: got %0d expected %0d", stall_cnt, m_stall);
        end
`endif
        req_valid = '0;
        wfull     = 1'b0;
    endtask

    // Final report
    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_max_burst();
        test_stall();
        test_owner_drop();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
